cu_edge_data_read_command_control: RTL and testbench

Issue-side scheduler for the edge-data read path of the PageRank-push compute unit. It pops edge jobs from the CU edge-job FIFO and turns each destination vertex ID into a single cacheline read command. It throttles issue against command-buffer back-pressure and a bounded outstanding-request budget, and retires requests as read responses return. It feeds the read-data extraction stage with commands whose tags (cacheline offset, destination ID, CU ID) the data returning from memory carries back.

---
 rtl/cu_edge_data_read_command_control_pkg.sv | 68 ++++++
 rtl/cu_edge_data_read_command_control_if.sv | 33 +++
 rtl/cu_edge_data_read_command_control_credit.sv | 62 ++++++
 rtl/cu_edge_data_read_command_control.sv | 181 ++++++++++++++++++
 tb/tb_cu_edge_data_read_command_control.sv | 349 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/cu_edge_data_read_command_control_pkg.sv
// rtl/cu_edge_data_read_command_control_pkg.sv - shared types and helpers for the CU edge-data read path
//
// Purpose: FSM state enum, command/response/FIFO line structs, outstanding
//          budget default and the byte-to-cacheline address helper that the
//          data-read control also uses to decode offsets.
// Ports:   none (package).

package cu_edge_data_read_command_control_pkg;

  localparam int EDGE_DATA_READ_MAX_OUTSTANDING = 32;
  localparam int DATA_SIZE_READ                 = 4;
  localparam int CACHELINE_BYTES                = 128;
  localparam int CACHELINE_OFFSET_W             = 7;
  localparam int CU_ID_W                        = 8;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ISSUE = 3'd1,
    STALL = 3'd2,
    DRAIN = 3'd3,
    DONE  = 3'd4
  } edge_data_read_cmd_state;

  typedef enum logic [1:0] {
    CMD_INVALID = 2'd0,
    READ_CL_NA  = 2'd1,
    READ_CL_S   = 2'd2,
    WRITE_NA    = 2'd3
  } command_type;

  typedef struct packed {
    logic        valid;
    logic [31:0] dest;
  } EdgeInterface;

  typedef struct packed {
    logic alfull;
  } BufferStatus;

  typedef struct packed {
    logic               valid;
    logic [CU_ID_W-1:0] cu_id;
  } ResponseBufferLine;

  typedef struct packed {
    logic                          valid;
    command_type                   command;
    logic [63:0]                   address;
    logic [7:0]                    size;
    logic [CU_ID_W-1:0]            cu_id;
    logic [CACHELINE_OFFSET_W-1:0] cacheline_offest;
    logic [63:0]                   address_offest;
  } CommandBufferLine;

  typedef struct packed {
    logic [63:0]                   address;
    logic [CACHELINE_OFFSET_W-1:0] offset;
  } cacheline_addr_t;

  // Cacheline-aligned address plus the element index inside that line.
  function automatic cacheline_addr_t get_edge_data_cacheline_addr(input logic [63:0] byte_addr);
    cacheline_addr_t r;
    r.address = {byte_addr[63:CACHELINE_OFFSET_W], {CACHELINE_OFFSET_W{1'b0}}};
    r.offset  = CACHELINE_OFFSET_W'(byte_addr[CACHELINE_OFFSET_W-1:0] >> $clog2(DATA_SIZE_READ));
    return r;
  endfunction

endpackage

// File: rtl/cu_edge_data_read_command_control_if.sv
// rtl/cu_edge_data_read_command_control_if.sv - edge FIFO, command buffer and response bundle
//
// Purpose: groups the edge-job FIFO handshake, command-buffer status, read
//          responses and outgoing read commands.
// Ports:   slave  - the command control block (pops FIFO, issues commands).
//          master - the environment (FIFO, command buffer, memory responses).

interface cu_edge_data_read_command_control_if;
  import cu_edge_data_read_command_control_pkg::*;

  EdgeInterface      edge_job_in;
  logic              edge_request_out;
  BufferStatus       read_buffer_status_in;
  ResponseBufferLine read_response_in;
  CommandBufferLine  read_command_out;

  modport slave (
    input  edge_job_in,
    input  read_buffer_status_in,
    input  read_response_in,
    output edge_request_out,
    output read_command_out
  );

  modport master (
    output edge_job_in,
    output read_buffer_status_in,
    output read_response_in,
    input  edge_request_out,
    input  read_command_out
  );

endinterface

// File: rtl/cu_edge_data_read_command_control_credit.sv
// rtl/cu_edge_data_read_command_control_credit.sv - outstanding/reserved read credit counter
//
// Purpose: module cu_outstanding_credit_counter. Tracks reads in flight and
//          pops whose FIFO data has not yet arrived, so the budget check
//          covers the 1-cycle FIFO latency.
// Ports:   clock, rstn          - clock, async active-low reset
//          pop_in               - FIFO pop this cycle (data arrives next cycle)
//          issue_in             - command issued this cycle
//          retire_in            - matching response this cycle
//          outstanding_out      - registered in-flight count
//          outstanding_next_out - in-flight count after this cycle
//          pending_out          - a pop is awaiting its FIFO data
//          budget_full_out      - reserved count has reached MAX_OUTSTANDING

module cu_outstanding_credit_counter #(
  parameter int MAX_OUTSTANDING = 32
) (
  input  logic       clock,
  input  logic       rstn,
  input  logic       pop_in,
  input  logic       issue_in,
  input  logic       retire_in,
  output logic [7:0] outstanding_out,
  output logic [7:0] outstanding_next_out,
  output logic       pending_out,
  output logic       budget_full_out
);

  logic [7:0] outstanding_q, outstanding_d;
  logic       pending_q, pending_d;
  logic       retire_ok;
  logic [8:0] reserved;

  always_comb begin
    outstanding_d = outstanding_q;
    pending_d     = pop_in;
    // A response with nothing in flight is stale; it must not wrap the count.
    retire_ok     = retire_in && (outstanding_q != 8'd0);
    if (issue_in && !retire_ok) begin
      if (outstanding_q != 8'hFF) outstanding_d = outstanding_q + 8'd1;
    end else if (retire_ok && !issue_in) begin
      outstanding_d = outstanding_q - 8'd1;
    end
  end

  always_ff @(posedge clock or negedge rstn) begin
    if (!rstn) begin
      outstanding_q <= 8'd0;
      pending_q     <= 1'b0;
    end else begin
      outstanding_q <= outstanding_d;
      pending_q     <= pending_d;
    end
  end

  assign reserved             = {1'b0, outstanding_q} + {8'd0, pending_q};
  assign budget_full_out      = (reserved >= 9'(MAX_OUTSTANDING));
  assign outstanding_out      = outstanding_q;
  assign outstanding_next_out = outstanding_d;
  assign pending_out          = pending_q;

endmodule

// File: rtl/cu_edge_data_read_command_control.sv
// rtl/cu_edge_data_read_command_control.sv - edge-data read command scheduler
//
// Purpose: pops edge jobs, turns each dest vertex into one cacheline read
//          command, throttles on command-buffer alfull and an outstanding
//          budget, retires requests on matching responses.
// Ports:   clock, rstn          - clock, async active-low reset
//          enabled_in           - block enable (registered once)
//          num_edges_in         - edges in this job, sampled on IDLE->ISSUE
//          vertex_data_base_in  - byte base of the vertex-data array
//          bus (slave)          - edge FIFO, buffer status, responses, commands
//          outstanding_out      - reads in flight
//          done_out             - job complete
// Option:  CU_EDGE_DATA_READ_PERF_EN adds stall_cycles_out, issued_out and
//          max_outstanding_out, all cleared on IDLE->ISSUE.

module cu_edge_data_read_command_control
  import cu_edge_data_read_command_control_pkg::*;
#(
  parameter int CU_ID           = 1,
  parameter int MAX_OUTSTANDING = EDGE_DATA_READ_MAX_OUTSTANDING
) (
  input  logic                              clock,
  input  logic                              rstn,
  input  logic                              enabled_in,
  input  logic [31:0]                       num_edges_in,
  input  logic [63:0]                       vertex_data_base_in,
  cu_edge_data_read_command_control_if.slave bus,
  output logic [7:0]                        outstanding_out,
  output logic                              done_out
`ifdef CU_EDGE_DATA_READ_PERF_EN
  ,
  output logic [31:0]                       stall_cycles_out,
  output logic [31:0]                       issued_out,
  output logic [31:0]                       max_outstanding_out
`endif
);

  logic                    enabled_q, enabled_d;
  edge_data_read_cmd_state state_q, state_d;
  logic [31:0]             remaining_q, remaining_d;
  CommandBufferLine        read_command_q, read_command_d;

  logic            alfull, issue, retire, pop;
  logic            budget_full, pending;
  logic [7:0]      outstanding, outstanding_next;
  logic [63:0]     byte_addr;
  cacheline_addr_t line;

  assign enabled_d = enabled_in;
  assign alfull    = bus.read_buffer_status_in.alfull;
  // Issue follows FIFO data even when disabled: a pop already made must land.
  assign issue     = bus.edge_job_in.valid;
  assign retire    = bus.read_response_in.valid && (bus.read_response_in.cu_id == CU_ID_W'(CU_ID));

  cu_outstanding_credit_counter #(
    .MAX_OUTSTANDING (MAX_OUTSTANDING)
  ) u_credit (
    .clock                (clock),
    .rstn                 (rstn),
    .pop_in               (pop),
    .issue_in             (issue),
    .retire_in            (retire),
    .outstanding_out      (outstanding),
    .outstanding_next_out (outstanding_next),
    .pending_out          (pending),
    .budget_full_out      (budget_full)
  );

  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    pop         = 1'b0;
    case (state_q)
      IDLE: begin
        if (enabled_q) begin
          if (num_edges_in != 32'd0) begin
            state_d     = ISSUE;
            remaining_d = num_edges_in;
          end else begin
            state_d = DONE;
          end
        end
      end
      ISSUE: begin
        if (enabled_q) begin
          if (remaining_q == 32'd0) begin
            state_d = DRAIN;
          end else if (!alfull && !budget_full) begin
            pop         = 1'b1;
            remaining_d = remaining_q - 32'd1;
            if (remaining_q == 32'd1) state_d = DRAIN;
          end else begin
            state_d = STALL;
          end
        end
      end
      STALL: begin
        if (enabled_q && !alfull && !budget_full) state_d = ISSUE;
      end
      DRAIN: begin
        // Look at the next count so done follows the last response by one cycle.
        if (enabled_q && (outstanding_next == 8'd0) && !pending) state_d = DONE;
      end
      DONE: begin
        if (!enabled_q) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    read_command_d = '0;
    byte_addr      = vertex_data_base_in + (64'(bus.edge_job_in.dest) * 64'(DATA_SIZE_READ));
    line           = get_edge_data_cacheline_addr(byte_addr);
    if (issue) begin
      read_command_d.valid            = 1'b1;
      read_command_d.command          = READ_CL_NA;
      read_command_d.address          = line.address;
      read_command_d.size             = 8'(CACHELINE_BYTES);
      read_command_d.cu_id            = CU_ID_W'(CU_ID);
      read_command_d.cacheline_offest = line.offset;
      read_command_d.address_offest   = 64'(bus.edge_job_in.dest);
    end
  end

  always_ff @(posedge clock or negedge rstn) begin
    if (!rstn) begin
      enabled_q      <= 1'b0;
      state_q        <= IDLE;
      remaining_q    <= 32'd0;
      read_command_q <= '0;
    end else begin
      enabled_q      <= enabled_d;
      state_q        <= state_d;
      remaining_q    <= remaining_d;
      read_command_q <= read_command_d;
    end
  end

  assign bus.edge_request_out = pop;
  assign bus.read_command_out = read_command_q;
  assign outstanding_out      = outstanding;
  assign done_out             = (state_q == DONE);

`ifdef CU_EDGE_DATA_READ_PERF_EN
  logic [31:0] stall_cycles_q, stall_cycles_d;
  logic [31:0] issued_q, issued_d;
  logic [31:0] max_outstanding_q, max_outstanding_d;
  logic        job_start;

  always_comb begin
    job_start         = (state_q == IDLE) && (state_d == ISSUE);
    stall_cycles_d    = stall_cycles_q + ((state_q == STALL) ? 32'd1 : 32'd0);
    issued_d          = issued_q + (issue ? 32'd1 : 32'd0);
    max_outstanding_d = max_outstanding_q;
    if ({24'd0, outstanding} > max_outstanding_q) max_outstanding_d = {24'd0, outstanding};
    if (job_start) begin
      stall_cycles_d    = 32'd0;
      issued_d          = 32'd0;
      max_outstanding_d = 32'd0;
    end
  end

  always_ff @(posedge clock or negedge rstn) begin
    if (!rstn) begin
      stall_cycles_q    <= 32'd0;
      issued_q          <= 32'd0;
      max_outstanding_q <= 32'd0;
    end else begin
      stall_cycles_q    <= stall_cycles_d;
      issued_q          <= issued_d;
      max_outstanding_q <= max_outstanding_d;
    end
  end

  assign stall_cycles_out    = stall_cycles_q;
  assign issued_out          = issued_q;
  assign max_outstanding_out = max_outstanding_q;
`endif

endmodule

// File: tb/tb_cu_edge_data_read_command_control.sv
// tb/tb_cu_edge_data_read_command_control.sv - scoreboard bench for the edge-data read command control

module tb_cu_edge_data_read_command_control;
  import cu_edge_data_read_command_control_pkg::*;

  localparam int TB_CU_ID = 1;
  localparam int TB_MAX   = 8;

  logic        clock = 1'b0;
  logic        rstn = 1'b0;
  logic        enabled_in = 1'b0;
  logic [31:0] num_edges_in = 32'd0;
  logic [63:0] vertex_data_base_in = 64'd0;
  logic [7:0]  outstanding_out;
  logic        done_out;
`ifdef CU_EDGE_DATA_READ_PERF_EN
  logic [31:0] stall_cycles_out, issued_out, max_outstanding_out;
`endif

  cu_edge_data_read_command_control_if bus ();

  cu_edge_data_read_command_control #(
    .CU_ID           (TB_CU_ID),
    .MAX_OUTSTANDING (TB_MAX)
  ) dut (
    .clock               (clock),
    .rstn                (rstn),
    .enabled_in          (enabled_in),
    .num_edges_in        (num_edges_in),
    .vertex_data_base_in (vertex_data_base_in),
    .bus                 (bus),
    .outstanding_out     (outstanding_out),
    .done_out            (done_out)
`ifdef CU_EDGE_DATA_READ_PERF_EN
    ,
    .stall_cycles_out    (stall_cycles_out),
    .issued_out          (issued_out),
    .max_outstanding_out (max_outstanding_out)
`endif
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [31:0] dest;
    logic [63:0] addr;
    logic [6:0]  off;
  } vec_t;

  vec_t fifo_q[$];
  vec_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   pop_count = 0;
  int   cmd_count = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic push_vec(input logic [31:0] d, input logic [63:0] a, input logic [6:0] o);
    vec_t v;
    v.dest = d;
    v.addr = a;
    v.off  = o;
    fifo_q.push_back(v);
  endtask

  // FIFO model: data appears exactly one cycle after a pop; expected command queued then.
  initial begin
    bus.edge_job_in = '0;
    forever begin
      logic p;
      vec_t v;
      @(negedge clock);
      p = bus.edge_request_out;
      @(posedge clock);
      #1;
      bus.edge_job_in = '0;
      if (p && rstn) begin
        if (fifo_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL fifo_underrun: pop with empty fifo at %0t", $time);
        end else begin
          v = fifo_q.pop_front();
          bus.edge_job_in.valid = 1'b1;
          bus.edge_job_in.dest  = v.dest;
          exp_q.push_back(v);
          pop_count++;
        end
      end
    end
  end

  // Monitor: compares every presented command against the scoreboard head.
  initial begin
    forever begin
      vec_t v;
      @(negedge clock);
      if (bus.read_command_out.valid) begin
        cmd_count++;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL cmd_unexpected: address 0x%0h with nothing expected", bus.read_command_out.address);
        end else begin
          v = exp_q.pop_front();
          check("cmd_address", bus.read_command_out.address, v.addr);
          check("cmd_cacheline_offset", 64'(bus.read_command_out.cacheline_offest), 64'(v.off));
          check("cmd_address_offset", bus.read_command_out.address_offest, 64'(v.dest));
          check("cmd_cu_id", 64'(bus.read_command_out.cu_id), 64'(TB_CU_ID));
          check("cmd_type", 64'(bus.read_command_out.command), 64'(READ_CL_NA));
          check("cmd_size", 64'(bus.read_command_out.size), 64'd128);
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic send_resp(input logic [7:0] id);
    @(posedge clock);
    #1;
    bus.read_response_in.valid = 1'b1;
    bus.read_response_in.cu_id = id;
    @(posedge clock);
    #1;
    bus.read_response_in = '0;
  endtask

  task automatic start_job(input logic [31:0] n, input logic [63:0] base);
    enabled_in = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    num_edges_in        = n;
    vertex_data_base_in = base;
    enabled_in          = 1'b1;
  endtask

  task automatic wait_cmds(input int n, input string name);
    int k = 0;
    while (cmd_count < n && k < 200) begin
      @(negedge clock);
      k++;
    end
    check(name, 64'(cmd_count), 64'(n));
  endtask

  task automatic wait_pops(input int n, input string name);
    int k = 0;
    int seen = 0;
    while (seen < n && k < 200) begin
      @(negedge clock);
      #1;
      if (bus.edge_request_out) seen++;
      k++;
    end
    check(name, 64'(seen), 64'(n));
  endtask

  // Retires n requests; done must stay low until the last and rise one cycle after it.
  task automatic retire_all(input int n, input string name);
    for (int i = 0; i < n; i++) begin
      if (i == n - 1) check({name, "_done_before_last"}, 64'(done_out), 64'd0);
      send_resp(8'(TB_CU_ID));
    end
    check({name, "_done_after_last"}, 64'(done_out), 64'd1);
    check({name, "_outstanding_zero"}, 64'(outstanding_out), 64'd0);
  endtask

  initial begin
    int pop_base;
    int cmd_base;
    int cmd_at;
    int bad;
    int k;

    bus.read_buffer_status_in = '0;
    bus.read_response_in      = '0;

    repeat (3) @(posedge clock);
    #1;
    check("reset_edge_request", 64'(bus.edge_request_out), 64'd0);
    check("reset_cmd_valid", 64'(bus.read_command_out.valid), 64'd0);
    check("reset_cmd_address", bus.read_command_out.address, 64'd0);
    check("reset_outstanding", 64'(outstanding_out), 64'd0);
    check("reset_done", 64'(done_out), 64'd0);
    rstn = 1'b1;

    // Four dests straddling a cacheline boundary.
    push_vec(32'd0,  64'h1000, 7'd0);
    push_vec(32'd1,  64'h1000, 7'd1);
    push_vec(32'd31, 64'h1000, 7'd31);
    push_vec(32'd32, 64'h1080, 7'd0);
    start_job(32'd4, 64'h1000);
    wait_cmds(4, "t1_cmds");
    repeat (2) @(negedge clock);
    check("t1_outstanding", 64'(outstanding_out), 64'd4);
    retire_all(4, "t1");

    // Budget: responses withheld, only TB_MAX pops allowed.
    for (int i = 0; i < 10; i++) push_vec(32'(100 + i), 64'h2180, 7'(4 + i));
    pop_base = pop_count;
    cmd_base = cmd_count;
    start_job(32'd10, 64'h2000);
    repeat (40) @(negedge clock);
    check("t2_pops_at_budget", 64'(pop_count - pop_base), 64'(TB_MAX));
    check("t2_outstanding_at_budget", 64'(outstanding_out), 64'(TB_MAX));
    check("t2_no_request_when_full", 64'(bus.edge_request_out), 64'd0);
    send_resp(8'(TB_CU_ID));
    repeat (10) @(negedge clock);
    check("t2_one_more_pop", 64'(pop_count - pop_base), 64'(TB_MAX + 1));
    check("t2_outstanding_refilled", 64'(outstanding_out), 64'(TB_MAX));
    send_resp(8'(TB_CU_ID));
    wait_cmds(cmd_base + 10, "t2_cmds");
    repeat (2) @(negedge clock);
    check("t2_outstanding_full_again", 64'(outstanding_out), 64'(TB_MAX));
    retire_all(TB_MAX, "t2");

    // alfull for 10 cycles mid-stream; base chosen so the address wraps past 2^64.
    push_vec(32'd0,  64'hFFFF_FFFF_FFFF_FF80, 7'd16);
    push_vec(32'd8,  64'hFFFF_FFFF_FFFF_FF80, 7'd24);
    push_vec(32'd15, 64'hFFFF_FFFF_FFFF_FF80, 7'd31);
    push_vec(32'd16, 64'h0, 7'd0);
    push_vec(32'd17, 64'h0, 7'd1);
    push_vec(32'd40, 64'h0, 7'd24);
    pop_base = pop_count;
    cmd_base = cmd_count;
    start_job(32'd6, 64'hFFFF_FFFF_FFFF_FFC0);
    k = 0;
    while (pop_count - pop_base < 2 && k < 100) begin
      @(negedge clock);
      #1;
      k++;
    end
    check("t3_reached_midstream", 64'(pop_count - pop_base >= 2), 64'd1);
    @(posedge clock);
    #1;
    bus.read_buffer_status_in.alfull = 1'b1;
    bad    = 0;
    cmd_at = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      #1;
      if (bus.edge_request_out) bad++;
      if (i == 0) cmd_at = cmd_count;
    end
    check("t3_no_pop_during_alfull", 64'(bad), 64'd0);
    check("t3_at_most_one_cmd_after_alfull", 64'((cmd_count - cmd_at) <= 1), 64'd1);
    @(posedge clock);
    #1;
    bus.read_buffer_status_in.alfull = 1'b0;
    wait_cmds(cmd_base + 6, "t3_cmds");
    retire_all(6, "t3");

    // Same-cycle issue and retire at outstanding 3, then a foreign response.
    for (int i = 0; i < 5; i++) push_vec(32'(3 + 2 * i), 64'h0, 7'(3 + 2 * i));
    pop_base = pop_count;
    cmd_base = cmd_count;
    start_job(32'd5, 64'h0);
    wait_pops(3, "t4_first_three_pops");
    @(posedge clock);
    #1;
    bus.read_buffer_status_in.alfull = 1'b1;
    wait_cmds(cmd_base + 3, "t4_cmds_three");
    repeat (3) @(negedge clock);
    check("t4_outstanding_three", 64'(outstanding_out), 64'd3);
    @(posedge clock);
    #1;
    bus.read_buffer_status_in.alfull = 1'b0;
    wait_pops(1, "t4_fourth_pop");
    @(posedge clock);
    #1;
    bus.read_response_in.valid       = 1'b1;
    bus.read_response_in.cu_id       = 8'(TB_CU_ID);
    bus.read_buffer_status_in.alfull = 1'b1;
    @(posedge clock);
    #1;
    bus.read_response_in = '0;
    check("t4_simultaneous_inc_dec", 64'(outstanding_out), 64'd3);
    check("t4_pop_count", 64'(pop_count - pop_base), 64'd4);
    send_resp(8'(TB_CU_ID + 1));
    check("t4_foreign_cu_id_ignored", 64'(outstanding_out), 64'd3);
    @(posedge clock);
    #1;
    bus.read_buffer_status_in.alfull = 1'b0;
    wait_cmds(cmd_base + 5, "t4_cmds");
    repeat (2) @(negedge clock);
    check("t4_outstanding_four", 64'(outstanding_out), 64'd4);
    retire_all(4, "t4");

    // Empty job goes straight to DONE without popping.
    pop_base = pop_count;
    cmd_base = cmd_count;
    start_job(32'd0, 64'h3000);
    k = 0;
    while (!done_out && k < 20) begin
      @(negedge clock);
      k++;
    end
    check("t5_done_empty_job", 64'(done_out), 64'd1);
    check("t5_no_pop", 64'(pop_count - pop_base), 64'd0);
    check("t5_no_cmd", 64'(cmd_count - cmd_base), 64'd0);

    // Reset with 7 in flight; late responses must not wrap the counter.
    for (int i = 0; i < 10; i++) push_vec(32'(i), 64'h0, 7'(i));
    cmd_base = cmd_count;
    start_job(32'd10, 64'h0);
    wait_pops(7, "t6_seven_pops");
    @(posedge clock);
    #1;
    bus.read_buffer_status_in.alfull = 1'b1;
    wait_cmds(cmd_base + 7, "t6_cmds");
    repeat (3) @(negedge clock);
    check("t6_outstanding_seven", 64'(outstanding_out), 64'd7);
    #2;
    rstn       = 1'b0;
    enabled_in = 1'b0;
    #1;
    check("t6_rst_outstanding", 64'(outstanding_out), 64'd0);
    check("t6_rst_done", 64'(done_out), 64'd0);
    check("t6_rst_edge_request", 64'(bus.edge_request_out), 64'd0);
    check("t6_rst_cmd_valid", 64'(bus.read_command_out.valid), 64'd0);
    @(posedge clock);
    #1;
    rstn = 1'b1;
    fifo_q.delete();
    bus.read_buffer_status_in.alfull = 1'b0;
    for (int i = 0; i < 3; i++) send_resp(8'(TB_CU_ID));
    check("t6_late_responses_dropped", 64'(outstanding_out), 64'd0);
    check("t6_no_pop_after_reset", 64'(bus.edge_request_out), 64'd0);

    repeat (3) @(negedge clock);
    check("scoreboard_drained", 64'(exp_q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
